// File: rtl/md_unit_if.sv
// Bundle of MD-class request and result signals between the EX stage and md_unit.
interface md_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output start, md_op, rs_data, rt_data, cancel,
    input  busy, hi, lo, md_out
  );

  modport slave (
    input  start, md_op, rs_data, rt_data, cancel,
    output busy, hi, lo, md_out
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit holding HI/LO; results are staged at accept and committed after a fixed busy period.
// Optional feature: define MD_DIV0_KEEP_EN to leave HI/LO unchanged on divide by zero.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] cnt_r, cnt_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic [63:0] stage_r, stage_nxt_s;
  logic [63:0] res_s;
  logic        accept_s;

  // Signed divide on magnitudes so that 0x8000_0000 / -1 wraps to 0x8000_0000 without overflow.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a, mag_b, q, r;
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (a[31] ^ b[31]) begin
      q = 32'd0 - q;
    end else begin
      q = q;
    end
    if (a[31]) begin
      r = 32'd0 - r;
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  // Result for the presented op, {HI, LO}, captured into staging on accept
  always_comb begin
    res_s = 64'd0;
    case (md.md_op)
      OP_MULT:  res_s = {{32{md.rs_data[31]}}, md.rs_data} * {{32{md.rt_data[31]}}, md.rt_data};
      OP_MULTU: res_s = {32'd0, md.rs_data} * {32'd0, md.rt_data};
      OP_DIV, OP_DIVU: begin
        if (md.rt_data == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
          res_s = {hi_r, lo_r};
`else
          res_s = {md.rs_data, 32'hFFFF_FFFF};
`endif
        end else if (md.md_op == OP_DIV) begin
          res_s = div_signed(md.rs_data, md.rt_data);
        end else begin
          res_s = {md.rs_data % md.rt_data, md.rs_data / md.rt_data};
        end
      end
      default:  res_s = 64'd0;
    endcase
  end

  assign accept_s = md.start && !md.cancel && !busy_r;

  // Next-state and datapath update for the IDLE/RUN controller
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    stage_nxt_s = stage_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (md.md_op)
            OP_MULT, OP_MULTU: begin
              state_nxt_s = ST_RUN;
              cnt_nxt_s   = 32'(MULT_CYCLES - 1);
              busy_nxt_s  = 1'b1;
              stage_nxt_s = res_s;
            end
            OP_DIV, OP_DIVU: begin
              state_nxt_s = ST_RUN;
              cnt_nxt_s   = 32'(DIV_CYCLES - 1);
              busy_nxt_s  = 1'b1;
              stage_nxt_s = res_s;
            end
            OP_MTHI: hi_nxt_s = md.rs_data;
            OP_MTLO: lo_nxt_s = md.rs_data;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == 32'd0) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          hi_nxt_s    = stage_r[63:32];
          lo_nxt_s    = stage_r[31:0];
        end else begin
          cnt_nxt_s = cnt_r - 32'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and architectural registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 32'd0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      stage_r <= 64'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      stage_r <= stage_nxt_s;
    end
  end

  // mfhi/mflo read path, zero latency
  always_comb begin
    md.md_out = 32'd0;
    case (md.md_op)
      OP_MFHI: md.md_out = hi_r;
      OP_MFLO: md.md_out = lo_r;
      default: md.md_out = 32'd0;
    endcase
  end

  assign md.busy = busy_r;
  assign md.hi   = hi_r;
  assign md.lo   = lo_r;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the EX stage of the pipelined MIPS core. Consumes the MD-class instructions flagged by the decoder (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) together with the forwarded rs/rt operands. It holds the HI/LO architectural registers and runs multi-cycle mult/div operations. It exposes a `busy` flag that the hazard unit uses to stall subsequent MD-class instructions.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  EX-stage instruction is MD-class and valid this cycle
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- rs_data  in  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo source)
- rt_data  in  32  forwarded rt operand (divisor / multiplier)
- cancel  in  1  exception/eret flush this cycle; suppresses acceptance of the current op
- busy  out  1  registered; high while a mult/div is in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- md_out  out  32  combinational: hi when md_op==5, lo when md_op==6, else 0

## Operation
- Accept condition: `start && !cancel && !busy && reset`. An op is sampled at the rising edge where this condition holds.
- mult/multu: 64-bit signed/unsigned product of rs_data × rt_data. HI = [63:32], LO = [31:0].
- div/divu: signed/unsigned rs_data ÷ rt_data. LO = quotient (truncated toward zero); HI = remainder (same sign as dividend).
- Signed 0x8000_0000 ÷ 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- Divide by zero: see Configuration.
- Result computation: the result is computed at acceptance and held in a 64-bit staging register. HI/LO are updated only at completion, so hi/lo keep their old values while busy.
- mthi/mtlo: on acceptance, HI (resp. LO) ← rs_data at that edge. No busy cycles.
- mfhi/mflo: pure read through md_out; no state change.
- An MD op presented while busy is ignored; the hazard unit is responsible for stalling it.
- cancel has no effect on an operation already in flight. Once accepted, an op always completes.
- FSM states:
  - IDLE: accepts ops. Accepting mult/div → RUN with the counter loaded to MULT_CYCLES−1 or DIV_CYCLES−1.
  - RUN: the counter decrements each cycle. At the edge where the counter is 0, HI/LO ← staging and the FSM returns to IDLE.
- Reset (reset==0 at a rising edge): state = IDLE, counter = 0, busy = 0, HI = 0, LO = 0, staging = 0. Reset during RUN abandons the operation; HI/LO are not updated.

## Timing
- Accept edge T: busy = 1 from T through T+N, where N = MULT_CYCLES or DIV_CYCLES.
- Completion edge T+N: HI/LO get the new values and busy drops to 0. The result is visible from T+N.
- busy is high for exactly N cycles. A new op may be accepted at edge T+N+1 at the earliest.
- mthi/mtlo: the new value is visible on hi/lo the cycle after the accept edge.
- md_out is combinational from md_op/hi/lo with zero latency. The hazard unit stalls mfhi/mflo while `busy || (start && md_op in 1..4)`.
- Simultaneous start and cancel: the op is not accepted; no state change.
- reset low with start high: reset wins.

## Configuration
- `MD_DIV0_KEEP_EN` defined: div/divu with rt_data==0 completes with the normal DIV_CYCLES busy period and leaves HI/LO unchanged.
- `MD_DIV0_KEEP_EN` undefined: div/divu with rt_data==0 completes with HI = rs_data and LO = 0xFFFF_FFFF, for both signed and unsigned.

## Test plan
- mult of rs=0xFFFF_FFFE (−2) and rt=3 accepted at T → busy 5 cycles; at T+5, HI=0xFFFF_FFFF and LO=0xFFFF_FFFA. multu with the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- div of rs=−7 (0xFFFF_FFF9) and rt=2 → after 10 cycles LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. divu of 7 and 2 → LO=3, HI=1.
- mthi with rs=0x1234_5678, then mflo/mfhi on the next cycles → md_out=old LO, then 0x1234_5678. hi/lo stay unchanged while a mult is busy and update only at completion.
- start+cancel of a mult in the same cycle → busy stays 0 and HI/LO are unchanged. cancel asserted mid-RUN → the op still completes normally.
- div with rt=0 and rs=0xAAAA_0000 → with `MD_DIV0_KEEP_EN`, HI/LO are unchanged after 10 cycles; without it, HI=0xAAAA_0000 and LO=0xFFFF_FFFF.
- reset driven low on cycle 3 of a div → at the next edge busy=0, HI=LO=0, and the FSM is idle; a mult accepted afterwards completes in exactly 5 cycles.
